// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, skid-buffer state type and level-width helper
package fifo_pkg;

  localparam int FIFO_DATASIZE     = 8;
  localparam int FIFO_ADDRSIZE     = 4;
  localparam int FIFO_AFULL_THRESH = 12;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_t;

  // One extra bit so the level can represent a completely full FIFO.
  function automatic int lvl_w(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/wr_ingress_ctrl_if.sv
// rtl/wr_ingress_ctrl_if.sv - producer, pointer-block and status signals of the write ingress
interface wr_ingress_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);

  logic                s_valid;
  logic [DATASIZE-1:0] s_data;
  logic                s_ready;
  logic                full;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr_q2;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic [ADDRSIZE:0]   wlevel;
  logic                almost_full;
  logic                ptr_err;

  modport slave (
    input  s_valid, s_data, full, wptr, rptr_q2,
    output s_ready, winc, wdata, wlevel, almost_full, ptr_err
  );

  modport master (
    output s_valid, s_data, full, wptr, rptr_q2,
    input  s_ready, winc, wdata, wlevel, almost_full, ptr_err
  );

endinterface

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray to binary conversion
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  always_comb begin
    o_bin = '0;
    for (int k = 0; k < W; k++) begin
      o_bin[k] = ^(i_gray >> k);
    end
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// rtl/wr_ingress_ctrl.sv - write-domain ingress: 2-entry skid buffer feeding winc/wdata
// plus registered fill level, almost_full and sticky pointer-error flag
module wr_ingress_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = FIFO_DATASIZE,
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic              write_clk,
  input  logic              wrst_n,
  wr_ingress_ctrl_if.slave  bus
);

  localparam int LW = lvl_w(ADDRSIZE);
  localparam logic [LW-1:0] THRESH = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] DEPTH  = LW'(1 << ADDRSIZE);

  skid_state_t         r_state;
  skid_state_t         w_nxt_state;
  logic                r_out_v;
  logic [DATASIZE-1:0] r_out_d;
  logic                r_sk_v;
  logic [DATASIZE-1:0] r_sk_d;
  logic                r_s_ready;
  logic                w_accept;
  logic                w_drain;

  logic [LW-1:0]       w_wb;
  logic [LW-1:0]       w_rb;
  logic [LW-1:0]       w_diff;
  logic [LW-1:0]       r_wlevel;
  logic                r_almost_full;
  logic                r_ptr_err;

  assign w_accept = bus.s_valid & r_s_ready;
  assign w_drain  = r_out_v & ~bus.full;

  assign bus.s_ready     = r_s_ready;
  assign bus.winc        = w_drain;
  assign bus.wdata       = r_out_d;
  assign bus.wlevel      = r_wlevel;
  assign bus.almost_full = r_almost_full;
  assign bus.ptr_err     = r_ptr_err;

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      SK_EMPTY: if (w_accept) w_nxt_state = SK_ONE;
      SK_ONE: begin
        if (w_accept && !w_drain)      w_nxt_state = SK_TWO;
        else if (!w_accept && w_drain) w_nxt_state = SK_EMPTY;
      end
      SK_TWO:   if (w_drain) w_nxt_state = SK_ONE;
      default:  w_nxt_state = SK_EMPTY;
    endcase
  end

  always_ff @(posedge write_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= SK_EMPTY;
      r_out_v   <= 1'b0;
      r_out_d   <= '0;
      r_sk_v    <= 1'b0;
      r_sk_d    <= '0;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_s_ready <= (w_nxt_state != SK_TWO);
      case (r_state)
        SK_EMPTY: begin
          if (w_accept) begin
            r_out_v <= 1'b1;
            r_out_d <= bus.s_data;
          end
        end
        SK_ONE: begin
          if (w_accept && !w_drain) begin
            r_sk_v <= 1'b1;
            r_sk_d <= bus.s_data;
          end else if (w_accept && w_drain) begin
            r_out_d <= bus.s_data;
          end else if (w_drain) begin
            r_out_v <= 1'b0;
          end
        end
        SK_TWO: begin
          if (w_drain && r_sk_v) begin
            r_out_d <= r_sk_d;
            r_sk_v  <= 1'b0;
          end
        end
        default: begin
          r_out_v <= 1'b0;
          r_sk_v  <= 1'b0;
        end
      endcase
    end
  end

  gray2bin #(.W(LW)) u_wptr_g2b (.i_gray(bus.wptr),    .o_bin(w_wb));
  gray2bin #(.W(LW)) u_rptr_g2b (.i_gray(bus.rptr_q2), .o_bin(w_rb));

  // Modulo subtraction across the extra MSB handles pointer wrap.
  assign w_diff = w_wb - w_rb;

  always_ff @(posedge write_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wlevel      <= '0;
      r_almost_full <= 1'b0;
      r_ptr_err     <= 1'b0;
    end else begin
      r_wlevel      <= w_diff;
      r_almost_full <= (w_diff >= THRESH);
      if (w_diff > DEPTH) r_ptr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// tb/tb_wr_ingress_ctrl.sv - scoreboard bench for wr_ingress_ctrl with queue reference model
module tb_wr_ingress_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int LW  = AW + 1;
  localparam int THR = 12;

  logic write_clk = 1'b0;
  logic wrst_n    = 1'b0;
  always #5 write_clk = ~write_clk;

  wr_ingress_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  wr_ingress_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(THR)) dut (
    .write_clk (write_clk),
    .wrst_n    (wrst_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int cyc        = 0;
  int winc_cnt   = 0;
  int first_winc = 0;
  int last_winc  = 0;
  int first_acc  = -1;
  int ready_drop = 0;
  bit err_m      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] gray(input int v);
    logic [LW-1:0] b;
    b = LW'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic int lvl(input int w, input int r);
    return (w - r) & ((1 << LW) - 1);
  endfunction

  always @(posedge write_clk) cyc++;

  always @(negedge write_clk) begin
    if (wrst_n && bus.winc) begin
      logic [DW-1:0] e;
      chk("winc_while_full", 32'(bus.full), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(bus.wdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wdata_order", 32'(bus.wdata), 32'(e));
      end
      if (winc_cnt == 0) first_winc = cyc;
      last_winc = cyc;
      winc_cnt++;
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  // full_mode: 0 = low, 1 = high, 2 = toggle every cycle
  task automatic run_stream(input int nwords, input int maxcyc, input int valid_pct,
                            input int full_mode, output int acc);
    int idx;
    logic [DW-1:0] cur;
    idx = 0;
    acc = 0;
    cur = DW'($urandom);
    for (int c = 0; c < maxcyc && idx < nwords; c++) begin
      bus.s_valid = ($urandom_range(99) < valid_pct);
      bus.s_data  = cur;
      bus.full    = (full_mode == 1) ? 1'b1 : (full_mode == 2) ? c[0] : 1'b0;
      @(negedge write_clk);
      if (!bus.s_ready) ready_drop = 1;
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(cur);
        if (first_acc < 0) first_acc = cyc;
        idx++;
        acc++;
        cur = DW'($urandom);
      end
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic set_ptrs_chk(input int w, input int r, input string tag);
    int l;
    bus.wptr    = gray(w);
    bus.rptr_q2 = gray(r);
    tick();
    tick();
    l = lvl(w, r);
    if (l > (1 << AW)) err_m = 1'b1;
    chk({tag, "_wlevel"}, 32'(bus.wlevel), 32'(l));
    chk({tag, "_afull"},  32'(bus.almost_full), 32'(l >= THR));
    chk({tag, "_ptr_err"}, 32'(bus.ptr_err), 32'(err_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.full    = 1'b0;
    bus.wptr    = '0;
    bus.rptr_q2 = '0;

    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_winc", 32'(bus.winc), 0);
    chk("rst_wdata", 32'(bus.wdata), 0);
    chk("rst_wlevel", 32'(bus.wlevel), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ptr_err", 32'(bus.ptr_err), 0);

    tick();
    wrst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(bus.s_ready), 0);
    tick();
    chk("ready_first_edge", 32'(bus.s_ready), 1);

    // 20-word burst with full low
    winc_cnt = 0; first_acc = -1; ready_drop = 0;
    run_stream(20, 40, 100, 0, acc);
    repeat (3) tick();
    chk("burst_accepted", 32'(acc), 20);
    chk("burst_ready_drop", 32'(ready_drop), 0);
    chk("burst_winc_cnt", 32'(winc_cnt), 20);
    chk("burst_consecutive", 32'(last_winc - first_winc), 19);
    chk("burst_latency", 32'(first_winc - first_acc), 1);
    chk("burst_q_empty", 32'(exp_q.size()), 0);

    // full held high: two words absorbed, then backpressure
    winc_cnt = 0;
    run_stream(3, 6, 100, 1, acc);
    chk("full_accepted", 32'(acc), 2);
    chk("full_ready_low", 32'(bus.s_ready), 0);
    chk("full_no_winc", 32'(winc_cnt), 0);
    bus.full = 1'b0;
    repeat (4) tick();
    chk("release_winc_cnt", 32'(winc_cnt), 2);
    chk("release_consecutive", 32'(last_winc - first_winc), 1);
    chk("release_q_empty", 32'(exp_q.size()), 0);

    // full toggling with random valid
    run_stream(50, 600, 60, 2, acc);
    bus.full = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    chk("toggle_accepted", 32'(acc), 50);
    chk("toggle_q_empty", 32'(exp_q.size()), 0);

    // level and almost_full
    set_ptrs_chk(12, 0, "lvl12");
    set_ptrs_chk(12, 1, "lvl11");
    set_ptrs_chk(16, 0, "lvl_max");
    for (int i = 0; i < 6; i++) begin
      int r, d;
      r = $urandom_range(31);
      d = $urandom_range(16);
      set_ptrs_chk((r + d) % 32, r, "lvl_rand");
    end
    set_ptrs_chk(3, 30, "wrap");
    set_ptrs_chk(20, 0, "err_set");
    set_ptrs_chk(5, 5, "err_sticky");

    // reset while both skid stages are occupied
    bus.wptr = '0;
    bus.rptr_q2 = '0;
    run_stream(2, 6, 100, 1, acc);
    chk("two_ready_low", 32'(bus.s_ready), 0);
    #2;
    wrst_n = 1'b0;
    #1;
    exp_q.delete();
    err_m = 1'b0;
    chk("mid_rst_s_ready", 32'(bus.s_ready), 0);
    chk("mid_rst_winc", 32'(bus.winc), 0);
    chk("mid_rst_wdata", 32'(bus.wdata), 0);
    chk("mid_rst_wlevel", 32'(bus.wlevel), 0);
    chk("mid_rst_afull", 32'(bus.almost_full), 0);
    chk("mid_rst_ptr_err", 32'(bus.ptr_err), 0);
    tick();
    tick();
    bus.full = 1'b0;
    wrst_n = 1'b1;
    tick();
    winc_cnt = 0;
    run_stream(1, 5, 100, 0, acc);
    repeat (3) tick();
    chk("post_rst_accepted", 32'(acc), 1);
    chk("post_rst_winc_cnt", 32'(winc_cnt), 1);
    chk("post_rst_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
